// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - per-scanline sprite prefetch controller and pixel driver
//
// Purpose: during each horizontal blank, scans the 9 entity slots once and
// requests one SpriteROM line for every entity on the next line's tile row.
// The returned data fills a 16-column line buffer. That buffer is swapped
// into the display buffer at the end of the line, and then drives `colour`.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   entity_1..entity_9  [13:10] sprite id (F = unused), [9:8] orientation,
//                       [7:4] tile row, [3:0] tile column
//   counter_H/V         VGA counters (H 0..799, V 0..524)
//   rom_sprite_id/rom_orientation/rom_line_index/rom_read_enable
//                       registered SpriteROM request
//   rom_data            ROM line data, valid one clock after the request
//   busy                high while a scan is in progress
//   colour              registered pixel (1 white, 0 black)
module sprite_line_scheduler #(
    parameter int NUM_SLOTS = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] entity_1,
    input  logic [13:0] entity_2,
    input  logic [13:0] entity_3,
    input  logic [13:0] entity_4,
    input  logic [13:0] entity_5,
    input  logic [13:0] entity_6,
    input  logic [13:0] entity_7,
    input  logic [13:0] entity_8,
    input  logic [13:0] entity_9,
    input  logic [9:0]  counter_H,
    input  logic [9:0]  counter_V,
    output logic [3:0]  rom_sprite_id,
    output logic [1:0]  rom_orientation,
    output logic [2:0]  rom_line_index,
    output logic        rom_read_enable,
    input  logic [7:0]  rom_data,
    output logic        busy,
    output logic        colour
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [3:0]  slot;
    logic        drain_cnt;
    logic [3:0]  trow;
    logic [2:0]  lidx;

    logic [13:0] ent_in [0:NUM_SLOTS-1];
    logic [13:0] snap   [0:NUM_SLOTS-1];

    // Tag pipe: lines up each request's {match, column} with the ROM data
    // that comes back two edges after the request is issued.
    logic        tag1_valid, tag2_valid;
    logic [3:0]  tag1_col,   tag2_col;

    logic [7:0]  next_buf [0:15];
    logic [7:0]  disp_buf [0:15];
    logic [15:0] next_valid;
    logic [15:0] disp_valid;

    assign ent_in[0] = entity_1;
    assign ent_in[1] = entity_2;
    assign ent_in[2] = entity_3;
    assign ent_in[3] = entity_4;
    assign ent_in[4] = entity_5;
    assign ent_in[5] = entity_6;
    assign ent_in[6] = entity_7;
    assign ent_in[7] = entity_8;
    assign ent_in[8] = entity_9;

    // Line that the upcoming scan prefetches for (the line after the current one).
    logic [9:0] nv;
    assign nv = (counter_V == 10'd524) ? 10'd0 : counter_V + 10'd1;

    logic trigger;
    assign trigger = (state == ST_IDLE) && (counter_H == 10'd640) && (nv < 10'd480);

    logic [13:0] cur;
    logic        cur_match;
    assign cur       = snap[slot];
    assign cur_match = (cur[13:10] != 4'hF) && (cur[7:4] == trow);

    logic        do_write;
    assign do_write = tag2_valid && !next_valid[tag2_col];

    logic [3:0] h_col;
    logic [2:0] h_px;
    logic       active;
    logic       pixel;
    assign h_col  = 4'(counter_H / 10'd40);
    assign h_px   = 3'((counter_H % 10'd40) / 10'd5);
    assign active = (counter_H < 10'd640) && (counter_V < 10'd480);
    // Columns with no sprite show the white background.
    assign pixel  = disp_valid[h_col] ? disp_buf[h_col][h_px] : 1'b1;

    // Control path
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            slot            <= 4'd0;
            drain_cnt       <= 1'b0;
            trow            <= 4'd0;
            lidx            <= 3'd0;
            busy            <= 1'b0;
            rom_read_enable <= 1'b0;
            rom_sprite_id   <= 4'hF;
            rom_orientation <= 2'd0;
            rom_line_index  <= 3'd0;
            tag1_valid      <= 1'b0;
            tag1_col        <= 4'd0;
            tag2_valid      <= 1'b0;
            tag2_col        <= 4'd0;
            next_valid      <= 16'd0;
            disp_valid      <= 16'd0;
            colour          <= 1'b0;
        end else begin
            tag1_valid <= (state == ST_SCAN) && cur_match;
            tag1_col   <= cur[3:0];
            tag2_valid <= tag1_valid;
            tag2_col   <= tag1_col;

            // First writer to a column wins, so lower slots take priority.
            if (do_write)
                next_valid[tag2_col] <= 1'b1;

            case (state)
                ST_IDLE: begin
                    rom_read_enable <= 1'b0;
                    busy            <= 1'b0;
                    if (trigger) begin
                        state      <= ST_SCAN;
                        slot       <= 4'd0;
                        trow       <= 4'(nv / 10'd40);
                        lidx       <= 3'((nv % 10'd40) / 10'd5);
                        next_valid <= 16'd0;
                    end
                end
                ST_SCAN: begin
                    busy            <= 1'b1;
                    rom_sprite_id   <= cur[13:10];
                    rom_orientation <= cur[9:8];
                    rom_line_index  <= lidx;
                    rom_read_enable <= cur_match;
                    if (slot == 4'(NUM_SLOTS - 1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        slot <= slot + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    rom_read_enable <= 1'b0;
                    if (!drain_cnt) begin
                        busy      <= 1'b1;
                        drain_cnt <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    rom_read_enable <= 1'b0;
                    busy            <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase

            if (counter_H == 10'd799)
                disp_valid <= next_valid;

            colour <= active ? pixel : 1'b0;
        end
    end

    // Data path: contents are only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (trigger) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                snap[i] <= ent_in[i];
        end
        if (do_write)
            next_buf[tag2_col] <= rom_data;
        if (counter_H == 10'd799) begin
            for (int i = 0; i < 16; i++)
                disp_buf[i] <= next_buf[i];
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - randomized self-checking bench for sprite_line_scheduler
module tb_sprite_line_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] ent [0:8];
    logic [9:0]  counter_H, counter_V;
    logic [3:0]  rom_sprite_id;
    logic [1:0]  rom_orientation;
    logic [2:0]  rom_line_index;
    logic        rom_read_enable;
    logic [7:0]  rom_data;
    logic        busy;
    logic        colour;

    int total = 0;
    int bad   = 0;

    // Reference state: what the line buffers should hold.
    bit [7:0] m_next [16];
    bit [7:0] m_disp [16];
    bit       m_next_v [16];
    bit       m_disp_v [16];

    always #5 clk = ~clk;

    sprite_line_scheduler dut (
        .clk(clk), .reset(reset),
        .entity_1(ent[0]), .entity_2(ent[1]), .entity_3(ent[2]),
        .entity_4(ent[3]), .entity_5(ent[4]), .entity_6(ent[5]),
        .entity_7(ent[6]), .entity_8(ent[7]), .entity_9(ent[8]),
        .counter_H(counter_H), .counter_V(counter_V),
        .rom_sprite_id(rom_sprite_id), .rom_orientation(rom_orientation),
        .rom_line_index(rom_line_index), .rom_read_enable(rom_read_enable),
        .rom_data(rom_data), .busy(busy), .colour(colour)
    );

    function automatic logic [7:0] pat(input logic [3:0] id, input logic [1:0] o,
                                       input logic [2:0] l);
        return {id, o, 2'b01} ^ {l, 5'b10110} ^ {o, 6'h2A} ^ 8'h3C;
    endfunction

    // SpriteROM: one-clock read latency.
    always @(posedge clk) rom_data <= pat(rom_sprite_id, rom_orientation, rom_line_index);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] mk(input int id, input int o, input int loc);
        return {4'(id), 2'(o), 8'(loc)};
    endfunction

    task automatic all_unused();
        for (int s = 0; s < 9; s++) ent[s] = mk(15, 0, 0);
    endtask

    // Runs one full line at V=v. mutate_h / reset_h (or -1) select edges after
    // which entity_1 is changed, or at which reset is asserted.
    task automatic run_line(input int v, input int mutate_h, input int reset_h);
        int nv, trow, lidx, col, px;
        bit scan, alive, exp_re, exp_busy, exp_col;
        bit [8:0] mm;
        logic [3:0] mid [9];
        logic [1:0] mor [9];
        int err_col, err_re, err_busy, obs_reads, exp_reads;
        nv   = (v == 524) ? 0 : v + 1;
        scan = nv < 480;
        trow = nv / 40;
        lidx = (nv % 40) / 5;
        err_col = 0; err_re = 0; err_busy = 0; obs_reads = 0; exp_reads = 0;
        alive = 1;
        mm = '0;
        for (int h = 0; h < 800; h++) begin
            counter_H = 10'(h);
            counter_V = 10'(v);
            if (h == 640 && scan) begin
                for (int c = 0; c < 16; c++) m_next_v[c] = 0;
                for (int s = 0; s < 9; s++) begin
                    mid[s] = ent[s][13:10];
                    mor[s] = ent[s][9:8];
                    mm[s]  = (ent[s][13:10] != 4'hF) && (int'(ent[s][7:4]) == trow);
                    col    = int'(ent[s][3:0]);
                    if (mm[s] && !m_next_v[col]) begin
                        m_next_v[col] = 1;
                        m_next[col]   = pat(mid[s], mor[s], 3'(lidx));
                    end
                end
            end
            if (h == reset_h) reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (h == mutate_h) ent[0] = {ent[0][13:8], 4'd5, ent[0][3:0]};
            if (h == reset_h) begin
                alive = 0;
                for (int c = 0; c < 16; c++) begin
                    m_next_v[c] = 0;
                    m_disp_v[c] = 0;
                end
            end
            if (h < 640 && v < 480 && h != reset_h) begin
                col = h / 40;
                px  = (h % 40) / 5;
                exp_col = m_disp_v[col] ? m_disp[col][px] : 1'b1;
            end else begin
                exp_col = 0;
            end
            exp_re   = scan && alive && h >= 641 && h <= 649 && mm[(h >= 641 && h <= 649) ? h - 641 : 0];
            exp_busy = scan && alive && h >= 641 && h <= 650;
            if (colour !== exp_col) err_col++;
            if (rom_read_enable !== exp_re) err_re++;
            if (busy !== exp_busy) err_busy++;
            if (rom_read_enable === 1'b1) obs_reads++;
            if (exp_re) begin
                exp_reads++;
                check_eq("rom_id", rom_sprite_id, mid[h - 641]);
                check_eq("rom_orient", rom_orientation, mor[h - 641]);
                check_eq("rom_line", rom_line_index, lidx);
            end
            if (h == 799) begin
                for (int c = 0; c < 16; c++) begin
                    m_disp[c]   = m_next[c];
                    m_disp_v[c] = m_next_v[c];
                end
            end
        end
        check_eq("reads", obs_reads, exp_reads);
        check_eq("re_timing_errs", err_re, 0);
        check_eq("busy_errs", err_busy, 0);
        check_eq("colour_errs", err_col, 0);
    endtask

    initial begin
        int v, r;
        reset = 1'b1;
        counter_H = '0;
        counter_V = '0;
        all_unused();
        for (int c = 0; c < 16; c++) begin
            m_next_v[c] = 0; m_disp_v[c] = 0; m_next[c] = 0; m_disp[c] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_re", rom_read_enable, 0);
        check_eq("rst_id", rom_sprite_id, 4'hF);
        check_eq("rst_orient", rom_orientation, 0);
        check_eq("rst_line", rom_line_index, 0);
        check_eq("rst_colour", colour, 0);
        reset = 1'b0;

        // Single entity on tile (2,1)
        all_unused();
        ent[0] = mk(3, 0, 8'h21);
        run_line(79, -1, -1);
        run_line(80, -1, -1);

        // Two entities sharing tile (0,0): slot 2 wins
        all_unused();
        ent[1] = mk(6, 1, 8'h00);
        ent[4] = mk(9, 2, 8'h00);
        run_line(0, -1, -1);
        run_line(1, -1, -1);

        // Empty, then off-screen rows
        all_unused();
        run_line(10, -1, -1);
        run_line(11, -1, -1);
        for (int s = 0; s < 9; s++) ent[s] = mk(s, 0, 8'hD0 + s);
        run_line(12, -1, -1);
        run_line(13, -1, -1);

        // Frame wrap and line index
        all_unused();
        ent[2] = mk(4, 3, 8'h05);
        ent[7] = mk(7, 0, 8'h0A);
        run_line(524, -1, -1);
        run_line(0, -1, -1);
        run_line(38, -1, -1);
        run_line(39, -1, -1);
        run_line(479, -1, -1);
        run_line(480, -1, -1);

        // Snapshot: entity_1 moves right after the trigger edge
        all_unused();
        ent[0] = mk(2, 1, 8'h23);
        run_line(100, 640, -1);
        run_line(101, -1, -1);

        // Reset in the middle of a scan, then normal operation
        all_unused();
        ent[0] = mk(1, 0, 8'h30);
        ent[3] = mk(5, 2, 8'h32);
        ent[8] = mk(8, 1, 8'h3F);
        run_line(120, -1, 645);
        run_line(121, -1, -1);
        run_line(122, -1, -1);

        // Randomized pairs of consecutive lines
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, 524);
            r = ((v == 524) ? 0 : v + 1) / 40;
            for (int s = 0; s < 9; s++) begin
                ent[s] = mk(($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 14),
                            $urandom_range(0, 3),
                            {4'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : r),
                             4'($urandom_range(0, 5))});
            end
            run_line(v, -1, -1);
            run_line((v == 524) ? 0 : v + 1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline sprite prefetch controller for the 640x480 tile renderer (16x12 tiles of 40 px; 8x8 sprites upscaled x5). During each horizontal blank it scans the 9 entity slots once, issues SpriteROM line reads for every entity on the next line's tile row, and fills a 16-column line buffer. It then drives `colour` for that next line from the buffer. It sits between the game-logic entity registers and the SpriteROM, and is the ROM's only reader.

## Interface
Parameters:
- `NUM_SLOTS`, 9: entity slots scanned per line (fixed geometry; not intended to change).

Ports:
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  synchronous, active-high.
- `entity_1` … `entity_9`  in  14 each  entity word: [13:10] sprite ID (4'hF = unused), [9:8] orientation, [7:0] tile location (row = [7:4], column = [3:0]).
- `counter_H`, `counter_V`  in  10 each  VGA counters; H runs 0..799, V runs 0..524; active area is H<640, V<480.
- `rom_sprite_id`  out  4  registered ROM sprite select.
- `rom_orientation`  out  2  registered ROM orientation.
- `rom_line_index`  out  3  registered ROM line select.
- `rom_read_enable`  out  1  registered read strobe.
- `rom_data`  in  8  ROM line data, valid one clock after the request is registered.
- `busy`  out  1  high while a scan is in progress.
- `colour`  out  1  registered pixel: 1 white, 0 black.

## Operation
- State machine: IDLE → SCAN (9 cycles, slot 0..8) → DRAIN (2 cycles) → IDLE.
- Scan trigger: in IDLE, on a clock edge with `counter_H`==640 and `nv`<480, where `nv` = (`counter_V`==524) ? 0 : `counter_V`+1. Take a snapshot of all 9 entity words, clear all 16 `next_valid` bits, and latch `trow` = `nv`/40 and `lidx` = (`nv`%40)/5. When `nv`≥480 there is no scan, and the next buffer stays as it is.
- SCAN at slot k: match = (ID≠4'hF) && (loc[7:4]==`trow`). Register `rom_*` from snapshot k with `rom_read_enable`=match and `rom_line_index`=`lidx`. Push {match, loc[3:0]} into a 2-stage tag pipe.
- Write stage: when tag stage 2 is valid and `next_valid[col]`==0, write `rom_data` into `next_buf[col]` and set `next_valid[col]`. Otherwise ignore the data. This gives the lowest slot number priority when two entities share a tile.
- DRAIN: `rom_read_enable`=0. The tag pipe flushes and the last write completes.
- Entity rows 12..15 never match. A change to an entity input during a scan has no effect because the scan uses the snapshot.
- Swap: on a clock edge with `counter_H`==799, copy `disp_buf`/`disp_valid` ← `next_buf`/`next_valid`. This happens independently of the FSM state.
- Colour: when H<640 and V<480, with col = H/40 and px = (H%40)/5: `colour` = `disp_valid[col]` ? `disp_buf[col][px]` : 1. Outside the active area, `colour` = 0.

## Timing
- Reset values: state IDLE; `busy`=0, `rom_read_enable`=0, `rom_sprite_id`=4'hF, `rom_orientation`=0, `rom_line_index`=0, `colour`=0; all valid bits in both buffers and the tag pipe = 0.
- A reset asserted mid-scan aborts the scan. The FSM restarts only at the next trigger.
- Trigger edge E0; ROM requests for slots 0..8 at edges E1..E9; writes at E3..E11; DRAIN covers E10..E11; IDLE and `busy`=0 after E11.
- `busy` is high for edges E1 through E10 inclusive. The scan completes at H=651, well inside the blank.
- `colour` has a 1-cycle latency from `counter_H`/`counter_V`.
- Line v+1 displays the data prefetched during line v's blank.
- Frame wrap: the scan during V=479 has `nv`=480 and is skipped. The scan during V=524 prefetches line 0.

## Test plan
- Single entity: `entity_1`=ID 3, orient 0, loc 0x21, others ID F; run the counters through V=79/80. Required: exactly one `rom_read_enable` pulse with `rom_line_index`=0 at H=641. On line 80, `colour` for H 40..79 follows `rom_data` bits [0]..[7], each held 5 px; all other columns are 1.
- Slot priority: `entity_2` and `entity_5` both at loc 0x00 with different ROM patterns. Required: 2 ROM reads, and column 0 shows `entity_2`'s pattern.
- Empty and off-screen: all slots ID F, or loc row 13. Required: no ROM reads; `colour`=1 across the active area and 0 in the blank.
- Line index and wrap: scan during V=524 gives `trow`=0, `lidx`=0. Scan at V=38 (`nv`=39) gives `lidx`=7. Scan at V=479 gives no `busy` pulse.
- Snapshot: change `entity_1` loc on the edge after E0. Required: the requests use the old value.
- Reset at E5: required `busy`=0 and `rom_read_enable`=0 next cycle; no buffer writes; a normal scan at the next H=640.
